// File: rtl/sub3_inverse_serial.sv
// Bit-serial reconstruction A = R + B + C (mod 2^WIDTH), DIGIT bits per cycle, with wrap flag.
// Optional saturation on wrap enabled by defining SUB3_INV_SAT_EN.
module sub3_inverse_serial #(
  parameter int WIDTH  = 16,
  parameter int CWIDTH = 11,
  parameter int DIGIT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_r,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [CWIDTH-1:0] in_c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_a,
  output logic              out_ovf
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int SW    = DIGIT + 2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

  generate
    if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0) || (CWIDTH > WIDTH)) begin : g_param_check
      $error("sub3_inverse_serial: DIGIT must divide WIDTH and CWIDTH must not exceed WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] r_sh, b_sh, c_sh, acc, acc_nxt, result_a;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       carry;
  logic [SW-1:0]    dsum;
  logic             last_digit, wrap_nxt;

  assign last_digit = (cnt == LAST);

`ifdef SUB3_INV_SAT_EN
  function automatic logic [WIDTH-1:0] sat_a(input logic [WIDTH-1:0] sum, input logic wrap);
    return wrap ? {WIDTH{1'b1}} : sum;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN:  if (last_digit) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Digit sum is DIGIT+2 bits so a carry of up to 2 survives intact
  always_comb begin
    dsum     = SW'(r_sh[DIGIT-1:0]) + SW'(b_sh[DIGIT-1:0]) + SW'(c_sh[DIGIT-1:0]) + SW'(carry);
    wrap_nxt = (dsum[DIGIT+1:DIGIT] != 2'b00);
`ifdef SUB3_INV_SAT_EN
    result_a = sat_a(acc_nxt, wrap_nxt);
`else
    result_a = acc_nxt;
`endif
  end

  generate
    if (DIGIT == WIDTH) begin : g_single
      assign acc_nxt = dsum[DIGIT-1:0];
    end else begin : g_multi
      assign acc_nxt = {dsum[DIGIT-1:0], acc[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      carry   <= 2'b00;
      out_a   <= '0;
      out_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          r_sh  <= in_r;
          b_sh  <= in_b;
          c_sh  <= WIDTH'(in_c);
          carry <= 2'b00;
          cnt   <= '0;
        end
        RUN: begin
          r_sh  <= r_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          c_sh  <= c_sh >> DIGIT;
          acc   <= acc_nxt;
          carry <= dsum[DIGIT+1:DIGIT];
          cnt   <= cnt + 1'b1;
          if (last_digit) begin
            out_a   <= result_a;
            out_ovf <= wrap_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sub3_inverse_serial.sv
// Self-checking bench for sub3_inverse_serial: vector table, corner sequences and random scoreboard run.
module tb_sub3_inverse_serial;
  localparam int W = 16, CW = 11, DIG = 4, NDIG = W / DIG;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ovf;
  logic          out_ready = 1'b1;
  logic          ready_req = 1'b1;
  bit            rand_stall = 1'b0;
  logic [W-1:0]  in_r, in_b, out_a;
  logic [CW-1:0] in_c;
  int            n_checks = 0, n_fail = 0;

  typedef struct packed {logic [W-1:0] a; logic ovf;} exp_t;
  typedef struct {logic [W-1:0] r; logic [W-1:0] b; logic [CW-1:0] c; logic [W-1:0] a; logic ovf;} vec_t;
  exp_t sb[$];
  vec_t vecs[10];

  always #5 clk = ~clk;

  sub3_inverse_serial #(.WIDTH(W), .CWIDTH(CW), .DIGIT(DIG)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_b(in_b), .in_c(in_c), .out_valid(out_valid),
    .out_ready(out_ready), .out_a(out_a), .out_ovf(out_ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t adjust(input logic [W-1:0] a, input logic ovf);
    exp_t e;
    e.a = a;
    e.ovf = ovf;
`ifdef SUB3_INV_SAT_EN
    if (ovf) e.a = '1;
`endif
    return e;
  endfunction

  function automatic exp_t model(input logic [W-1:0] r, input logic [W-1:0] b, input logic [CW-1:0] c);
    logic [W+1:0] s;
    s = {2'b00, r} + {2'b00, b} + {{(W+2-CW){1'b0}}, c};
    return adjust(s[W-1:0], s[W+1:W] != 2'b00);
  endfunction

  // out_ready has a single driver; it changes 2 time units after each rising edge
  always @(posedge clk) begin
    #2;
    out_ready = rand_stall ? 1'($urandom_range(0, 1)) : ready_req;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got a=0x%0h required no result", out_a);
      end else begin
        e = sb.pop_front();
        check("out_a", out_a, e.a);
        check("out_ovf", out_ovf, e.ovf);
      end
    end
  end

  // Called 1 time unit after a rising edge; returns edges from accept until out_valid is seen
  task automatic send(input logic [W-1:0] r, input logic [W-1:0] b, input logic [CW-1:0] c,
                      input exp_t e, output int lat);
    int k;
    in_r = r; in_b = b; in_c = c; in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 required 1");
    end else begin
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    lat = k;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, sb.size(), 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    vecs[0] = '{16'h0000, 16'h0000, 11'h000, 16'h0000, 1'b0};
    vecs[1] = '{16'h1234, 16'h0001, 11'h001, 16'h1236, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0001, 11'h000, 16'h0000, 1'b1};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 11'h7FF, 16'h07FD, 1'b1};
    vecs[4] = '{16'h0010, 16'h0020, 11'h003, 16'h0033, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 11'h000, 16'h0000, 1'b1};
    vecs[6] = '{16'h7FFF, 16'h0000, 11'h001, 16'h8000, 1'b0};
    vecs[7] = '{16'h0F0F, 16'hF0F0, 11'h000, 16'hFFFF, 1'b0};
    vecs[8] = '{16'h0F0F, 16'hF0F0, 11'h001, 16'h0000, 1'b1};
    vecs[9] = '{16'hABCD, 16'h1111, 11'h123, 16'hBE01, 1'b0};

    in_valid = 1'b0; in_r = '0; in_b = '0; in_c = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_a", out_a, 0);
    check("reset_out_ovf", out_ovf, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      send(vecs[i].r, vecs[i].b, vecs[i].c, adjust(vecs[i].a, vecs[i].ovf), lat);
      check("latency", lat, NDIG);
    end
    drain("table_drain");

    // Reset while the third digit is pending discards the operation
    in_r = 16'h1234; in_b = 16'h0001; in_c = 11'h001; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrun_rst_out_valid", out_valid, 0);
    check("midrun_rst_in_ready", in_ready, 1);
    check("midrun_rst_out_a", out_a, 0);
    check("midrun_rst_out_ovf", out_ovf, 0);
    repeat (NDIG + 2) @(posedge clk);
    #1;
    check("midrun_rst_no_result", out_valid, 0);
    send(16'h0010, 16'h0020, 11'h003, adjust(16'h0033, 1'b0), lat);
    drain("post_reset_drain");

    // Backpressure: result held, new operands refused
    ready_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(16'hABCD, 16'h1111, 11'h123, adjust(16'hBE01, 1'b0), lat);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_r = 16'($urandom); in_b = 16'($urandom); in_c = 11'($urandom);
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_a", out_a, 16'hBE01);
      check("bp_out_ovf", out_ovf, 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    ready_req = 1'b1;
    drain("bp_drain");
    send(16'hFFFF, 16'hFFFF, 11'h7FF, adjust(16'h07FD, 1'b1), lat);
    drain("bp_next_drain");

    // Random operands against the reference model with random output stalls
    rand_stall = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      logic [W-1:0] r, b;
      logic [CW-1:0] c;
      r = 16'($urandom); b = 16'($urandom); c = 11'($urandom);
      if (i % 7 == 0) begin r = '1; b = '1; end
      send(r, b, c, model(r, b, c), lat);
    end
    drain("random_drain");
    rand_stall = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
